vesa_timing_gen: RTL and testbench

Parametrised, dual-mode successor to the fixed 1024x768 VESA sync generator. Produces hsync, vsync, optional composite sync, video_on, the current pixel coordinates, and line/frame strobes from a single pixel clock with a pixel-enable qualifier. Selects between two compile-time timing sets at frame boundaries only. Sits between the clock generator (`sys_clock`, 75 MHz for mode 0) and the game renderer/VGA pins.

---
 rtl/vesa_timing_pkg.sv | 38 +++
 rtl/vesa_axis_counter.sv | 73 +++++++
 rtl/vesa_timing_gen.sv | 161 ++++++++++++++++
 tb/tb_vesa_timing_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vesa_timing_pkg.sv
// -----------------------------------------------------------------------------
// vesa_timing_pkg
// Shared timing description for the VESA sync generator.
//   axis_timing_t   : active / front porch / sync / back porch lengths plus
//                     sync polarity (1 = active-high) for one axis
//   axis_total      : total counts per line (or lines per frame) of an axis
//   axis_sync_start : first count of the sync region
//   axis_valid      : every region length is non-zero
//   H0/V0/H1/V1_DEFAULT : 1024x768 (mode 0) and 800x600 (mode 1) timing sets
// -----------------------------------------------------------------------------
package vesa_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
    logic        pol;
  } axis_timing_t;

  function automatic int unsigned axis_total(input axis_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  function automatic int unsigned axis_sync_start(input axis_timing_t t);
    return t.active + t.fp;
  endfunction

  function automatic bit axis_valid(input axis_timing_t t);
    return (t.active != 0) && (t.fp != 0) && (t.sync != 0) && (t.bp != 0);
  endfunction

  localparam axis_timing_t H0_DEFAULT = '{active: 1024, fp: 24, sync: 136, bp: 144, pol: 1'b0};
  localparam axis_timing_t V0_DEFAULT = '{active: 768,  fp: 3,  sync: 6,   bp: 29,  pol: 1'b0};
  localparam axis_timing_t H1_DEFAULT = '{active: 800,  fp: 40, sync: 128, bp: 88,  pol: 1'b1};
  localparam axis_timing_t V1_DEFAULT = '{active: 600,  fp: 1,  sync: 4,   bp: 23,  pol: 1'b1};

endpackage

// File: rtl/vesa_axis_counter.sv
// -----------------------------------------------------------------------------
// vesa_axis_counter
// One timing axis (horizontal or vertical). Holds the position counter and
// exposes the decode of the position it will hold after this edge, so the
// parent can register sync/active levels in lock-step with the counter.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset (counter -> T0 last)
//   step_i        : advance the counter this edge
//   mode_cur_i    : mode of the current frame (selects wrap point)
//   mode_nxt_i    : mode the next position belongs to (selects decode set)
//   cnt_o         : current count
//   last_o        : current count is the final count of the axis
//   act_d_o       : next position lies in the active region
//   sync_d_o      : next position lies in the sync region
// -----------------------------------------------------------------------------
module vesa_axis_counter
  import vesa_timing_pkg::*;
#(
  parameter int           COORD_W = 11,
  parameter axis_timing_t T0      = H0_DEFAULT,
  parameter axis_timing_t T1      = H1_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               step_i,
  input  logic               mode_cur_i,
  input  logic               mode_nxt_i,
  output logic [COORD_W-1:0] cnt_o,
  output logic               last_o,
  output logic               act_d_o,
  output logic               sync_d_o
);

  localparam logic [COORD_W-1:0] LAST0 = COORD_W'(axis_total(T0) - 1);
  localparam logic [COORD_W-1:0] LAST1 = COORD_W'(axis_total(T1) - 1);
  localparam logic [COORD_W-1:0] ACT0  = COORD_W'(T0.active);
  localparam logic [COORD_W-1:0] ACT1  = COORD_W'(T1.active);
  localparam logic [COORD_W-1:0] SS0   = COORD_W'(axis_sync_start(T0));
  localparam logic [COORD_W-1:0] SS1   = COORD_W'(axis_sync_start(T1));
  localparam logic [COORD_W-1:0] SE0   = COORD_W'(axis_sync_start(T0) + T0.sync);
  localparam logic [COORD_W-1:0] SE1   = COORD_W'(axis_sync_start(T1) + T1.sync);

  logic [COORD_W-1:0] cnt_q, cnt_d;
  logic [COORD_W-1:0] act_lim, ss_lim, se_lim;

  assign last_o = (cnt_q == (mode_cur_i ? LAST1 : LAST0));

  always_comb begin
    cnt_d = cnt_q;
    if (step_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Decode uses the mode of the next position: at a frame wrap the (0,0)
  // pixel already belongs to the newly latched mode.
  assign act_lim  = mode_nxt_i ? ACT1 : ACT0;
  assign ss_lim   = mode_nxt_i ? SS1  : SS0;
  assign se_lim   = mode_nxt_i ? SE1  : SE0;
  assign act_d_o  = (cnt_d < act_lim);
  assign sync_d_o = (cnt_d >= ss_lim) && (cnt_d < se_lim);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= LAST0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vesa_timing_gen.sv
// -----------------------------------------------------------------------------
// vesa_timing_gen
// Dual-mode VESA sync generator. Two compile-time timing sets; the requested
// mode is latched only when the raster wraps to (0,0).
// Ports:
//   clk, rst    : pixel clock, synchronous active-high reset
//   pix_en      : counters advance only when high
//   mode_sel    : requested mode, sampled at frame wrap
//   hsync/vsync : syncs with per-mode polarity
//   csync       : composite sync, active-low (constant 1 unless enabled)
//   video_on    : inside active area
//   pixel_x/y   : raw counters including blanking
//   line_start  : pulse when pixel_x becomes 0
//   frame_start : pulse when (pixel_x,pixel_y) becomes (0,0)
//   mode_cur    : mode in effect for the current frame
// Optional feature macro: VESA_CSYNC_EN (serrated composite sync on csync).
// All outputs are registered and describe the current counter position.
// -----------------------------------------------------------------------------
module vesa_timing_gen
  import vesa_timing_pkg::*;
#(
  parameter int          COORD_W   = 11,
  parameter int unsigned H0_ACTIVE = H0_DEFAULT.active,
  parameter int unsigned H0_FP     = H0_DEFAULT.fp,
  parameter int unsigned H0_SYNC   = H0_DEFAULT.sync,
  parameter int unsigned H0_BP     = H0_DEFAULT.bp,
  parameter int unsigned V0_ACTIVE = V0_DEFAULT.active,
  parameter int unsigned V0_FP     = V0_DEFAULT.fp,
  parameter int unsigned V0_SYNC   = V0_DEFAULT.sync,
  parameter int unsigned V0_BP     = V0_DEFAULT.bp,
  parameter bit          H0_POL    = H0_DEFAULT.pol,
  parameter bit          V0_POL    = V0_DEFAULT.pol,
  parameter int unsigned H1_ACTIVE = H1_DEFAULT.active,
  parameter int unsigned H1_FP     = H1_DEFAULT.fp,
  parameter int unsigned H1_SYNC   = H1_DEFAULT.sync,
  parameter int unsigned H1_BP     = H1_DEFAULT.bp,
  parameter int unsigned V1_ACTIVE = V1_DEFAULT.active,
  parameter int unsigned V1_FP     = V1_DEFAULT.fp,
  parameter int unsigned V1_SYNC   = V1_DEFAULT.sync,
  parameter int unsigned V1_BP     = V1_DEFAULT.bp,
  parameter bit          H1_POL    = H1_DEFAULT.pol,
  parameter bit          V1_POL    = V1_DEFAULT.pol
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  input  logic               mode_sel,
  output logic               hsync,
  output logic               vsync,
  output logic               csync,
  output logic               video_on,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               line_start,
  output logic               frame_start,
  output logic               mode_cur
);

  localparam axis_timing_t H0_T = '{active: H0_ACTIVE, fp: H0_FP, sync: H0_SYNC, bp: H0_BP, pol: H0_POL};
  localparam axis_timing_t V0_T = '{active: V0_ACTIVE, fp: V0_FP, sync: V0_SYNC, bp: V0_BP, pol: V0_POL};
  localparam axis_timing_t H1_T = '{active: H1_ACTIVE, fp: H1_FP, sync: H1_SYNC, bp: H1_BP, pol: H1_POL};
  localparam axis_timing_t V1_T = '{active: V1_ACTIVE, fp: V1_FP, sync: V1_SYNC, bp: V1_BP, pol: V1_POL};
  localparam longint unsigned COORD_RANGE = 64'd1 << COORD_W;

  if (longint'(axis_total(H0_T)) > COORD_RANGE || longint'(axis_total(V0_T)) > COORD_RANGE ||
      longint'(axis_total(H1_T)) > COORD_RANGE || longint'(axis_total(V1_T)) > COORD_RANGE) begin : g_bad_total
    $error("vesa_timing_gen: a timing TOTAL exceeds 2**COORD_W");
  end
  if (!axis_valid(H0_T) || !axis_valid(V0_T) || !axis_valid(H1_T) || !axis_valid(V1_T)) begin : g_bad_region
    $error("vesa_timing_gen: a timing region length is zero");
  end

  logic mode_cur_q, mode_d;
  logic h_last, v_last, frame_wrap;
  logic h_act_d, v_act_d, h_sync_d, v_sync_d;
  logic h_pol_d, v_pol_d;
  logic hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;

  assign frame_wrap = pix_en & h_last & v_last;
  assign mode_d     = frame_wrap ? mode_sel : mode_cur_q;
  assign h_pol_d    = mode_d ? H1_POL : H0_POL;
  assign v_pol_d    = mode_d ? V1_POL : V0_POL;

  vesa_axis_counter #(
    .COORD_W (COORD_W),
    .T0      (H0_T),
    .T1      (H1_T)
  ) u_h (
    .clk_i      (clk),
    .rst_i      (rst),
    .step_i     (pix_en),
    .mode_cur_i (mode_cur_q),
    .mode_nxt_i (mode_d),
    .cnt_o      (pixel_x),
    .last_o     (h_last),
    .act_d_o    (h_act_d),
    .sync_d_o   (h_sync_d)
  );

  vesa_axis_counter #(
    .COORD_W (COORD_W),
    .T0      (V0_T),
    .T1      (V1_T)
  ) u_v (
    .clk_i      (clk),
    .rst_i      (rst),
    .step_i     (pix_en & h_last),
    .mode_cur_i (mode_cur_q),
    .mode_nxt_i (mode_d),
    .cnt_o      (pixel_y),
    .last_o     (v_last),
    .act_d_o    (v_act_d),
    .sync_d_o   (v_sync_d)
  );

  // Output register stage: aligned with the counter flops.
  // The reset position (TOTAL-1) is always in the back porch, so syncs are
  // inactive and video is off there.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_cur_q    <= 1'b0;
      video_on_q    <= 1'b0;
      hsync_q       <= ~H0_POL;
      vsync_q       <= ~V0_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      mode_cur_q    <= mode_d;
      video_on_q    <= h_act_d & v_act_d;
      hsync_q       <= h_sync_d ~^ h_pol_d;
      vsync_q       <= v_sync_d ~^ v_pol_d;
      line_start_q  <= pix_en & h_last;
      frame_start_q <= frame_wrap;
    end
  end

`ifdef VESA_CSYNC_EN
  logic csync_q;

  // Serrated composite: low during hsync outside vsync, inverted inside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      csync_q <= 1'b1;
    end else begin
      csync_q <= ~(h_sync_d ^ v_sync_d);
    end
  end

  assign csync = csync_q;
`else
  assign csync = 1'b1;
`endif

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign mode_cur    = mode_cur_q;

endmodule

// File: tb/tb_vesa_timing_gen.sv
// -----------------------------------------------------------------------------
// Bench for vesa_timing_gen: two instances (default timings and a tiny
// timing set that wraps frames quickly) share stimulus. An integer raster
// model predicts every output each cycle; a monitor compares.
// -----------------------------------------------------------------------------
module tb_vesa_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, pix_en, mode_sel;

  logic        a_hs, a_vs, a_cs, a_von, a_ls, a_fs, a_mode;
  logic [10:0] a_x, a_y;
  logic        b_hs, b_vs, b_cs, b_von, b_ls, b_fs, b_mode;
  logic [10:0] b_x, b_y;

  vesa_timing_gen u_dut_a (
    .clk(clk), .rst(rst), .pix_en(pix_en), .mode_sel(mode_sel),
    .hsync(a_hs), .vsync(a_vs), .csync(a_cs), .video_on(a_von),
    .pixel_x(a_x), .pixel_y(a_y), .line_start(a_ls), .frame_start(a_fs),
    .mode_cur(a_mode)
  );

  vesa_timing_gen #(
    .COORD_W(11),
    .H0_ACTIVE(10), .H0_FP(2), .H0_SYNC(3), .H0_BP(2),
    .V0_ACTIVE(6),  .V0_FP(1), .V0_SYNC(2), .V0_BP(1),
    .H0_POL(1'b0),  .V0_POL(1'b1),
    .H1_ACTIVE(8),  .H1_FP(1), .H1_SYNC(2), .H1_BP(3),
    .V1_ACTIVE(5),  .V1_FP(2), .V1_SYNC(1), .V1_BP(3),
    .H1_POL(1'b1),  .V1_POL(1'b0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .pix_en(pix_en), .mode_sel(mode_sel),
    .hsync(b_hs), .vsync(b_vs), .csync(b_cs), .video_on(b_von),
    .pixel_x(b_x), .pixel_y(b_y), .line_start(b_ls), .frame_start(b_fs),
    .mode_cur(b_mode)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        cs;
    logic        von;
    logic [10:0] x;
    logic [10:0] y;
    logic        ls;
    logic        fs;
    logic        mode;
  } obs_t;

  obs_t act_a, act_b;
  assign act_a = {a_hs, a_vs, a_cs, a_von, a_x, a_y, a_ls, a_fs, a_mode};
  assign act_b = {b_hs, b_vs, b_cs, b_von, b_x, b_y, b_ls, b_fs, b_mode};

  // [dut][mode] = {ha, hfp, hs, hbp, hpol, va, vfp, vs, vbp, vpol}
  int tbl [2][2][10] = '{
    '{'{1024, 24, 136, 144, 0, 768, 3, 6, 29, 0}, '{800, 40, 128, 88, 1, 600, 1, 4, 23, 1}},
    '{'{10, 2, 3, 2, 0, 6, 1, 2, 1, 1},           '{8, 1, 2, 3, 1, 5, 2, 1, 3, 0}}
  };

  int mx [2];
  int my [2];
  int mm [2];
  bit mls [2];
  bit mfs [2];

  obs_t qa [$];
  obs_t qb [$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  function automatic int htot(int d, int m);
    return tbl[d][m][0] + tbl[d][m][1] + tbl[d][m][2] + tbl[d][m][3];
  endfunction

  function automatic int vtot(int d, int m);
    return tbl[d][m][5] + tbl[d][m][6] + tbl[d][m][7] + tbl[d][m][8];
  endfunction

  // Raster model: where the beam is after this clock edge.
  function automatic void model_step(int d, bit r, bit pe, bit ms);
    if (r) begin
      mx[d] = htot(d, 0) - 1;
      my[d] = vtot(d, 0) - 1;
      mm[d] = 0;
      mls[d] = 0;
      mfs[d] = 0;
    end else if (pe) begin
      mls[d] = (mx[d] == htot(d, mm[d]) - 1);
      mfs[d] = mls[d] && (my[d] == vtot(d, mm[d]) - 1);
      if (mfs[d]) begin
        mx[d] = 0; my[d] = 0; mm[d] = ms;
      end else if (mls[d]) begin
        mx[d] = 0; my[d] = my[d] + 1;
      end else begin
        mx[d] = mx[d] + 1;
      end
    end else begin
      mls[d] = 0;
      mfs[d] = 0;
    end
  endfunction

  function automatic obs_t model_out(int d);
    obs_t o;
    int m, hss, vss;
    bit h_in, v_in;
    m   = mm[d];
    hss = tbl[d][m][0] + tbl[d][m][1];
    vss = tbl[d][m][5] + tbl[d][m][6];
    h_in = (mx[d] >= hss) && (mx[d] < hss + tbl[d][m][2]);
    v_in = (my[d] >= vss) && (my[d] < vss + tbl[d][m][7]);
    o.hs   = (tbl[d][m][4] != 0) ? h_in : !h_in;
    o.vs   = (tbl[d][m][9] != 0) ? v_in : !v_in;
`ifdef VESA_CSYNC_EN
    o.cs   = !(h_in ^ v_in);
`else
    o.cs   = 1'b1;
`endif
    o.von  = (mx[d] < tbl[d][m][0]) && (my[d] < tbl[d][m][5]);
    o.x    = 11'(mx[d]);
    o.y    = 11'(my[d]);
    o.ls   = mls[d];
    o.fs   = mfs[d];
    o.mode = mm[d][0];
    return o;
  endfunction

  task automatic drive(input bit r, input bit pe, input bit ms);
    @(negedge clk);
    rst = r;
    pix_en = pe;
    mode_sel = ms;
    model_step(0, r, pe, ms);
    model_step(1, r, pe, ms);
    qa.push_back(model_out(0));
    qb.push_back(model_out(1));
  endtask

  function automatic void check(string name, obs_t got, obs_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual hs=%b vs=%b cs=%b von=%b x=%0d y=%0d ls=%b fs=%b mode=%b required hs=%b vs=%b cs=%b von=%b x=%0d y=%0d ls=%b fs=%b mode=%b",
               name, cyc, got.hs, got.vs, got.cs, got.von, got.x, got.y, got.ls, got.fs, got.mode,
               exp.hs, exp.vs, exp.cs, exp.von, exp.x, exp.y, exp.ls, exp.fs, exp.mode);
    end
  endfunction

  // Monitor: one expected observation per DUT per clock edge.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check("dut_default", act_a, e);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check("dut_small", act_b, e);
      end
    end
  end

  initial begin
    bit ms;
    rst = 1'b1;
    pix_en = 1'b0;
    mode_sel = 1'b0;

    // reset held, pix_en ignored while rst is high
    drive(1, 0, 0);
    drive(1, 1, 1);
    drive(1, 0, 0);

    // continuous advance; mode_sel wiggles mid-frame on the default instance
    for (int i = 0; i < 2 * 1328 + 40; i++) drive(0, 1, bit'((i / 300) % 2));

    // alternating pix_en doubles the line period
    for (int i = 0; i < 2800; i++) drive(0, bit'(i % 2), bit'((i / 200) % 2));

    // reset mid-line while pix_en is high, then resume
    drive(1, 1, 1);
    drive(0, 1, 1);
    for (int i = 0; i < 200; i++) drive(0, 1, 1);

    // randomised traffic: rare resets, mostly-advancing pix_en, mode flips
    ms = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      if ($urandom_range(0, 39) == 0) ms = ~ms;
      drive(($urandom_range(0, 999) == 0), ($urandom_range(0, 3) != 0), ms);
    end

    @(posedge clk);
    #2;
    tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      fails++;
      $display("FAIL drain actual pending=%0d required pending=0", qa.size() + qb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
